// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD combinational reads, two write ports, optional
// write-to-read forwarding, and a per-register busy scoreboard with a live count.
module regfile_mp_sb #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] qd,
  output logic [NRD-1:0]    qbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wn0,
  input  logic [DW-1:0]     d0,
  input  logic              we1,
  input  logic [AW-1:0]     wn1,
  input  logic [DW-1:0]     d1,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [AW:0]       busy_cnt,
  output logic              addr_err
);

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREG;
  endfunction

  // Valid = backed by real storage; the hardwired zero register is not.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  logic [DW-1:0]   mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     rises;
  logic [AW:0]     falls;
  logic            wv0;
  logic            wv1;
  logic            iss_v;
  logic            oor;

  assign wv0   = we0 && addr_valid(wn0);
  assign wv1   = we1 && addr_valid(wn1);
  assign iss_v = iss_en && addr_valid(iss_rd);
  assign oor   = (we0 && !in_range(wn0)) || (we1 && !in_range(wn1)) ||
                 (iss_en && !in_range(iss_rd));

  // NOTE: the storage array is cleared by the async reset because software
  // relies on every register reading 0 after reset; this costs a reset flop
  // per bit instead of a plain RAM, so do not copy it where contents may be X.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wv1 && wn1 == AW'(r))      mem[r] <= d1;
        else if (wv0 && wn0 == AW'(r)) mem[r] <= d0;
      end
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what keeps synthesis from inferring a latch.
  always_comb begin
    busy_nxt = busy;
    rises    = '0;
    falls    = '0;
    for (int r = 0; r < NREG; r++) begin
      // A same-cycle issue marks a newer producer, so set beats clear.
      busy_nxt[r] = (iss_v && iss_rd == AW'(r)) ||
                    (busy[r] && !((wv0 && wn0 == AW'(r)) || (wv1 && wn1 == AW'(r))));
      rises = rises + {{AW{1'b0}}, busy_nxt[r] & ~busy[r]};
      falls = falls + {{AW{1'b0}}, busy[r] & ~busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy     <= '0;
      busy_cnt <= '0;
      addr_err <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + rises - falls;
      addr_err <= addr_err | oor;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          hit0;
    logic          hit1;
    a     = '0;
    hit0  = 1'b0;
    hit1  = 1'b0;
    qd    = '0;
    qbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      a    = ra[k*AW +: AW];
      hit0 = wv0 && wn0 == a;
      hit1 = wv1 && wn1 == a;
      if (addr_valid(a)) begin
        if (BYPASS != 0 && hit1)      qd[k*DW +: DW] = d1;
        else if (BYPASS != 0 && hit0) qd[k*DW +: DW] = d0;
        else                          qd[k*DW +: DW] = mem[a];
        // Forwarded data is already available, so the hazard disappears.
        qbusy[k] = busy[a] && !(BYPASS != 0 && (hit0 || hit1));
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two configurations share one stimulus stream and are
// checked against hand-derived vectors plus a behavioural model via a scoreboard.
module tb_regfile_mp_sb;

  typedef struct {
    logic        we0;
    logic [4:0]  wn0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  wn1;
    logic [31:0] d1;
    logic        iss;
    logic [4:0]  rd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] q0;
    logic [31:0] q1;
    logic [1:0]  qb;
    logic [5:0]  cnt;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] q0;
    logic [31:0] q1;
    logic [1:0]  qb;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [9:0]  ra;
  logic        we0, we1, iss_en;
  logic [4:0]  wn0, wn1, iss_rd;
  logic [31:0] d0, d1;
  logic [63:0] qd_a, qd_b;
  logic [1:0]  qbusy_a, qbusy_b;
  logic [5:0]  cnt_a, cnt_b;
  logic        err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [2][32];
  logic [31:0] m_busy [2];
  logic        m_err  [2];
  exp_t        sb[$];
  vec_t        tab [16];

  always #5 clk = ~clk;

  regfile_mp_sb dut_a (
    .clk(clk), .clrn(clrn), .ra(ra), .qd(qd_a), .qbusy(qbusy_a),
    .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(cnt_a), .addr_err(err_a)
  );

  regfile_mp_sb #(.DW(32), .NREG(24), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .clrn(clrn), .ra(ra), .qd(qd_b), .qbusy(qbusy_b),
    .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(cnt_b), .addr_err(err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int m_nreg(input int i);
    return (i == 0) ? 32 : 24;
  endfunction

  function automatic bit m_valid(input int i, input logic [4:0] a);
    if (int'(a) >= m_nreg(i)) return 1'b0;
    if (i == 0 && a == 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_q(input int i, input logic [4:0] a);
    if (!m_valid(i, a)) return 32'd0;
    if (i == 0 && we1 && m_valid(i, wn1) && wn1 == a) return d1;
    if (i == 0 && we0 && m_valid(i, wn0) && wn0 == a) return d0;
    return m_regs[i][a];
  endfunction

  function automatic logic m_qb(input int i, input logic [4:0] a);
    if (!m_valid(i, a)) return 1'b0;
    if (i == 0 && ((we0 && m_valid(i, wn0) && wn0 == a) ||
                   (we1 && m_valid(i, wn1) && wn1 == a))) return 1'b0;
    return m_busy[i][a];
  endfunction

  function automatic exp_t m_exp(input int i);
    exp_t e;
    e.q0  = m_q(i, ra[4:0]);
    e.q1  = m_q(i, ra[9:5]);
    e.qb  = {m_qb(i, ra[9:5]), m_qb(i, ra[4:0])};
    e.cnt = 6'($countones(m_busy[i]));
    e.err = m_err[i];
    return e;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) m_regs[i][r] = 32'd0;
      m_busy[i] = 32'd0;
      m_err[i]  = 1'b0;
    end
  endtask

  // Applied in program order: port 1 overwrites port 0, issue overrides a clear.
  task automatic m_update();
    for (int i = 0; i < 2; i++) begin
      if (we0 && m_valid(i, wn0)) begin m_regs[i][wn0] = d0; m_busy[i][wn0] = 1'b0; end
      if (we1 && m_valid(i, wn1)) begin m_regs[i][wn1] = d1; m_busy[i][wn1] = 1'b0; end
      if (iss_en && m_valid(i, iss_rd)) m_busy[i][iss_rd] = 1'b1;
      if ((we0 && int'(wn0) >= m_nreg(i)) || (we1 && int'(wn1) >= m_nreg(i)) ||
          (iss_en && int'(iss_rd) >= m_nreg(i))) m_err[i] = 1'b1;
    end
  endtask

  task automatic drive(input vec_t v);
    we0 = v.we0; wn0 = v.wn0; d0 = v.d0;
    we1 = v.we1; wn1 = v.wn1; d1 = v.d1;
    iss_en = v.iss; iss_rd = v.rd;
    ra = {v.a1, v.a0};
  endtask

  function automatic vec_t idle(input logic [4:0] a0, input logic [4:0] a1);
    vec_t v;
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v.a0 = a0;
    v.a1 = a1;
    return v;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(input bit has_tab, input vec_t v, input bit do_rst);
    exp_t g;
    sb.push_back(m_exp(0));
    sb.push_back(m_exp(1));
    #1;
    g = sb.pop_front();
    check("a.qd0", qd_a[31:0], g.q0);   check("a.qd1", qd_a[63:32], g.q1);
    check("a.qbusy", qbusy_a, g.qb);    check("a.busy_cnt", cnt_a, g.cnt);
    check("a.addr_err", err_a, g.err);
    g = sb.pop_front();
    check("b.qd0", qd_b[31:0], g.q0);   check("b.qd1", qd_b[63:32], g.q1);
    check("b.qbusy", qbusy_b, g.qb);    check("b.busy_cnt", cnt_b, g.cnt);
    check("b.addr_err", err_b, g.err);
    if (has_tab) begin
      check("tab.qd0", qd_a[31:0], v.q0);  check("tab.qd1", qd_a[63:32], v.q1);
      check("tab.qbusy", qbusy_a, v.qb);   check("tab.busy_cnt", cnt_a, v.cnt);
      check("tab.addr_err", err_a, v.err);
    end
    if (do_rst) begin
      #1 clrn = 1'b0;
      m_reset();
      #1 clrn = 1'b1;
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 4));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    vec_t v;
    // we0 wn0 d0 | we1 wn1 d1 | iss rd | a0 a1 | q0 q1 qb cnt err  (dut_a: NREG=32, bypass, zero reg)
    tab[0]  = '{0, 0, 0,           0, 0, 0,       0, 0, 5,  0,  0,       0,       0, 0, 0};
    tab[1]  = '{1, 7, 'h1111,      1, 7, 'h2222,  0, 0, 7,  3,  'h2222,  0,       0, 0, 0};
    tab[2]  = '{0, 0, 0,           0, 0, 0,       0, 0, 7,  0,  'h2222,  0,       0, 0, 0};
    tab[3]  = '{1, 0, 'hFFFFFFFF,  0, 0, 0,       1, 0, 0,  7,  0,       'h2222,  0, 0, 0};
    tab[4]  = '{0, 0, 0,           0, 0, 0,       1, 3, 0,  3,  0,       0,       0, 0, 0};
    tab[5]  = '{0, 0, 0,           0, 0, 0,       1, 4, 3,  4,  0,       0,       1, 1, 0};
    tab[6]  = '{1, 3, 'hABCD,      0, 0, 0,       0, 0, 3,  4,  'hABCD,  0,       2, 2, 0};
    tab[7]  = '{0, 0, 0,           0, 0, 0,       0, 0, 3,  4,  'hABCD,  0,       2, 1, 0};
    tab[8]  = '{0, 0, 0,           0, 0, 0,       1, 9, 9,  4,  0,       0,       2, 1, 0};
    tab[9]  = '{0, 0, 0,           1, 9, 'h9999,  1, 9, 9,  4,  'h9999,  0,       2, 2, 0};
    tab[10] = '{0, 0, 0,           0, 0, 0,       0, 0, 9,  4,  'h9999,  0,       3, 2, 0};
    tab[11] = '{0, 0, 0,           0, 0, 0,       1, 4, 9,  3,  'h9999,  'hABCD,  1, 2, 0};
    tab[12] = '{1, 4, 5,           1, 4, 6,       0, 0, 4,  9,  6,       'h9999,  2, 2, 0};
    tab[13] = '{0, 0, 0,           0, 0, 0,       0, 0, 4,  9,  6,       'h9999,  2, 1, 0};
    tab[14] = '{1, 20, 'h77,       0, 0, 0,       0, 0, 20, 31, 'h77,    0,       0, 1, 0};
    tab[15] = '{0, 0, 0,           0, 0, 0,       0, 0, 20, 9,  'h77,    'h9999,  2, 1, 0};

    clrn = 1'b0;
    drive(idle(0, 0));
    m_reset();
    #7 clrn = 1'b1;
    @(negedge clk);

    foreach (tab[i]) begin
      drive(tab[i]);
      cycle(1'b1, tab[i], 1'b0);
    end

    // Out-of-range write on the 24-entry instance.
    v = idle(30, 7); v.we0 = 1; v.wn0 = 30; v.d0 = 32'h5A5A;
    drive(v); #1;
    check("b.err_before", err_b, 1'b0);
    cycle(1'b0, v, 1'b0);
    v = idle(30, 7); drive(v); #1;
    check("b.err_set", err_b, 1'b1);
    check("b.qd_oor", qd_b[31:0], 32'd0);
    check("b.qbusy_oor", qbusy_b[0], 1'b0);
    cycle(1'b0, v, 1'b0);

    // Dual write conflict without bypass: old value visible this cycle.
    v = idle(7, 9); v.we0 = 1; v.wn0 = 7; v.d0 = 32'h3333; v.we1 = 1; v.wn1 = 7; v.d1 = 32'h4444;
    drive(v); #1;
    check("b.nobypass_old", qd_b[31:0], 32'h2222);
    check("a.bypass_new", qd_a[31:0], 32'h4444);
    cycle(1'b0, v, 1'b0);

    // Ordinary reg 0 on the ZERO_REG=0 instance.
    v = idle(7, 9); v.we0 = 1; v.wn0 = 0; v.d0 = 32'h1234_5678; v.iss = 1; v.rd = 0;
    drive(v); #1;
    check("b.port1_won", qd_b[31:0], 32'h4444);
    check("b.err_sticky", err_b, 1'b1);
    cycle(1'b0, v, 1'b0);
    v = idle(0, 9); drive(v); #1;
    check("b.reg0_data", qd_b[31:0], 32'h1234_5678);
    check("b.reg0_busy", qbusy_b, 2'b11);
    check("b.busy_cnt", cnt_b, 6'd2);
    check("a.reg0_zero", qd_a[31:0], 32'd0);
    check("a.qbusy", qbusy_a, 2'b10);
    cycle(1'b0, v, 1'b0);

    // Asynchronous reset between clock edges.
    v = idle(5, 9); v.we0 = 1; v.wn0 = 5; v.d0 = 32'hDEADBEEF;
    drive(v);
    cycle(1'b0, v, 1'b0);
    drive(idle(5, 9)); #1;
    check("a.pre_reset", qd_a[31:0], 32'hDEADBEEF);
    #1 clrn = 1'b0;
    #1;
    check("rst.a.qd", qd_a, 64'd0);     check("rst.b.qd", qd_b, 64'd0);
    check("rst.a.cnt", cnt_a, 6'd0);    check("rst.b.cnt", cnt_b, 6'd0);
    check("rst.a.err", err_a, 1'b0);    check("rst.b.err", err_b, 1'b0);
    m_reset();
    #1 clrn = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 10000; n++) begin
      v = idle(rnd_addr(), rnd_addr());
      v.we0 = 1'($urandom_range(0, 1)); v.wn0 = rnd_addr(); v.d0 = $urandom;
      v.we1 = 1'($urandom_range(0, 1)); v.wn1 = rnd_addr(); v.d1 = $urandom;
      v.iss = 1'($urandom_range(0, 1)); v.rd  = rnd_addr();
      drive(v);
      cycle(1'b0, v, $urandom_range(0, 499) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
